// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
// Optional build macro: DMEM_BYTE_EN_EN (per-byte write enables).
package data_mem_responder_pkg;

    localparam int WORD_LEN = 32;
    localparam logic [WORD_LEN-1:0] DMEM_ADDR_BASE = 32'd1024;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // An address is unusable when misaligned, below the base, or past the last word.
    function automatic logic addr_bad(input logic [WORD_LEN-1:0] addr,
                                      input logic [WORD_LEN-1:0] base,
                                      input logic [WORD_LEN-1:0] depth);
        logic [WORD_LEN-1:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage <-> data memory responder bus.
// Handshake: the master holds MEM_R_EN or MEM_W_EN (with address/dataIn) until
// the slave pulses ready for one cycle; dataOut and err are valid with ready
// and hold until the next completion. stall asks the pipeline to freeze while
// the access is outstanding and drops on the ready cycle.
// Optional build macro: DMEM_BYTE_EN_EN adds byte_en.
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic                MEM_R_EN;
    logic                MEM_W_EN;
    logic [WORD_LEN-1:0] address;
    logic [WORD_LEN-1:0] dataIn;
`ifdef DMEM_BYTE_EN_EN
    logic [3:0]          byte_en;
`endif
    logic [WORD_LEN-1:0] dataOut;
    logic                ready;
    logic                stall;
    logic                err;

    modport master (
`ifdef DMEM_BYTE_EN_EN
        output byte_en,
`endif
        output MEM_R_EN, MEM_W_EN, address, dataIn,
        input  dataOut, ready, stall, err
    );

    modport slave (
`ifdef DMEM_BYTE_EN_EN
        input  byte_en,
`endif
        input  MEM_R_EN, MEM_W_EN, address, dataIn,
        output dataOut, ready, stall, err
    );

endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Word storage for the data memory responder: synchronous write, combinational
// read, whole array cleared on reset.
// Optional build macro: DMEM_BYTE_EN_EN (per-byte write mask).
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        we,
    input  logic [IDX_W-1:0]                            idx,
    input  logic [data_mem_responder_pkg::WORD_LEN-1:0] wdata,
`ifdef DMEM_BYTE_EN_EN
    input  logic [3:0]                                  be,
`endif
    output logic [data_mem_responder_pkg::WORD_LEN-1:0] rdata
);
    import data_mem_responder_pkg::*;

    logic [WORD_LEN-1:0] mem [DEPTH];

    // Clear on reset, otherwise update the addressed word (or its enabled lanes).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
`ifdef DMEM_BYTE_EN_EN
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
`else
            mem[idx] <= wdata;
`endif
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle responder for MEM-stage loads/stores: accepts a request in IDLE,
// waits out the latency, performs the access on the edge into RESP and pulses
// ready for one cycle. state_dbg exposes the FSM state.
// Optional build macro: DMEM_BYTE_EN_EN (per-byte write enables).
module data_mem_responder #(
    parameter int DEPTH = 64,
    parameter logic [data_mem_responder_pkg::WORD_LEN-1:0] ADDR_BASE =
        data_mem_responder_pkg::DMEM_ADDR_BASE,
    parameter int LATENCY = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    data_mem_responder_if.slave                 bus,
    output data_mem_responder_pkg::dmem_state_e state_dbg
);
    import data_mem_responder_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [WORD_LEN-1:0] DEPTH_W = WORD_LEN'(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dmem_state_e         state;
    logic [3:0]          cnt;
    logic                lat_rd, lat_wr;
    logic [WORD_LEN-1:0] lat_addr, lat_data;
    logic [WORD_LEN-1:0] data_out_q;
    logic                ready_q, err_q;

    logic                in_idle, req, op_rd, op_wr, op_bad, to_resp, we;
    logic [WORD_LEN-1:0] op_addr, op_data, rdata;
    logic [IDX_W-1:0]    idx;
`ifdef DMEM_BYTE_EN_EN
    logic [3:0]          lat_be, op_be;
`endif

    // Operation in effect: live inputs while IDLE (LATENCY==1 completes at once), latched copies after.
    always_comb begin
        in_idle = (state == DMEM_IDLE);
        req     = bus.MEM_R_EN | bus.MEM_W_EN;
        op_rd   = in_idle ? bus.MEM_R_EN : lat_rd;
        op_wr   = in_idle ? bus.MEM_W_EN : lat_wr;
        op_addr = in_idle ? bus.address  : lat_addr;
        op_data = in_idle ? bus.dataIn   : lat_data;
`ifdef DMEM_BYTE_EN_EN
        op_be   = in_idle ? bus.byte_en  : lat_be;
`endif
        idx     = IDX_W'((op_addr - ADDR_BASE) >> 2);
        op_bad  = addr_bad(op_addr, ADDR_BASE, DEPTH_W) || (op_rd && op_wr);
        to_resp = (in_idle && req && (LATENCY == 1)) ||
                  ((state == DMEM_WAIT) && (cnt == 4'd0));
        we      = to_resp && op_wr && !op_bad;
    end

    dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .idx   (idx),
        .wdata (op_data),
`ifdef DMEM_BYTE_EN_EN
        .be    (op_be),
`endif
        .rdata (rdata)
    );

    // FSM, latency counter, request latches and registered completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DMEM_IDLE;
            cnt        <= 4'd0;
            lat_rd     <= 1'b0;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
`ifdef DMEM_BYTE_EN_EN
            lat_be     <= 4'd0;
`endif
            data_out_q <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                DMEM_IDLE: begin
                    if (req) begin
                        lat_rd   <= bus.MEM_R_EN;
                        lat_wr   <= bus.MEM_W_EN;
                        lat_addr <= bus.address;
                        lat_data <= bus.dataIn;
`ifdef DMEM_BYTE_EN_EN
                        lat_be   <= bus.byte_en;
`endif
                        if (LATENCY == 1) begin
                            state <= DMEM_RESP;
                        end else begin
                            state <= DMEM_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                DMEM_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= DMEM_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DMEM_RESP: state <= DMEM_IDLE;
                default:   state <= DMEM_IDLE;
            endcase
            if (to_resp) begin
                ready_q <= 1'b1;
                err_q   <= op_bad;
                if (op_bad) begin
                    data_out_q <= '0;
                end else if (op_rd) begin
                    data_out_q <= rdata;
                end
            end
        end
    end

    assign bus.dataOut = data_out_q;
    assign bus.ready   = ready_q;
    assign bus.err     = err_q;
    assign bus.stall   = (in_idle && req) || (state == DMEM_WAIT);
    assign state_dbg   = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=3 instance and a LATENCY=1
// instance share the same request drivers; sel chooses which one is observed.
// Optional build macro: DMEM_BYTE_EN_EN (adds the byte-lane write steps).
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        r_en = 1'b0;
    logic        w_en = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] din = 32'd0;
    logic [3:0]  be = 4'hF;
    logic        sel = 1'b0;

    int total = 0;
    int bad = 0;

    dmem_state_e st3, st1;
    logic        o_ready, o_stall, o_err;
    logic [31:0] o_data, o_state;

    data_mem_responder_if bus3 ();
    data_mem_responder_if bus1 ();

    assign bus3.MEM_R_EN = r_en;
    assign bus3.MEM_W_EN = w_en;
    assign bus3.address  = addr;
    assign bus3.dataIn   = din;
    assign bus1.MEM_R_EN = r_en;
    assign bus1.MEM_W_EN = w_en;
    assign bus1.address  = addr;
    assign bus1.dataIn   = din;
`ifdef DMEM_BYTE_EN_EN
    assign bus3.byte_en  = be;
    assign bus1.byte_en  = be;
`endif

    data_mem_responder #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave), .state_dbg(st3)
    );

    data_mem_responder #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .state_dbg(st1)
    );

    always_comb begin
        o_ready = sel ? bus1.ready   : bus3.ready;
        o_stall = sel ? bus1.stall   : bus3.stall;
        o_err   = sel ? bus1.err     : bus3.err;
        o_data  = sel ? bus1.dataOut : bus3.dataOut;
        o_state = sel ? 32'(st1)     : 32'(st3);
    end

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        r_en = 1'b0;
        w_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one request, hold it until ready, check latency and stall profile.
    // With gap set, an idle cycle follows and ready must be low there.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          input int lat, input bit gap, input string tag);
        int   n_stall;
        int   n_cyc;
        logic got;
        @(negedge clk);
        r_en = r;
        w_en = w;
        addr = a;
        din  = d;
        be   = b;
        n_stall = 0;
        n_cyc   = 0;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (o_ready) begin
                got = 1'b1;
            end else begin
                if (o_stall) n_stall++;
                n_cyc++;
                @(negedge clk);
            end
        end
        check({tag, "_ready_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(n_cyc), 32'(lat));
        check({tag, "_stall_cycles"}, 32'(n_stall), 32'(lat));
        check({tag, "_stall_on_ready"}, 32'(o_stall), 32'd0);
        r_en = 1'b0;
        w_en = 1'b0;
        if (gap) begin
            @(negedge clk);
            #1;
            check({tag, "_ready_one_cycle"}, 32'(o_ready), 32'd0);
        end
    endtask

    initial begin
        logic seen;

        // reset state, LATENCY=3 instance
        sel = 1'b0;
        do_reset();
        #1;
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_stall", 32'(o_stall), 32'd0);
        check("rst_state", o_state, 32'(DMEM_IDLE));

        // first read of a cleared word
        access(1'b1, 1'b0, 32'd1024, 32'd0, 4'hF, 3, 1'b1, "rd1024");
        check("rd1024_data", o_data, 32'd0);
        check("rd1024_err", 32'(o_err), 32'd0);

        // write then back-to-back read of the same word
        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'hF, 3, 1'b0, "wr1028");
        check("wr1028_data_unchanged", o_data, 32'd0);
        check("wr1028_err", 32'(o_err), 32'd0);
        access(1'b1, 1'b0, 32'd1028, 32'd0, 4'hF, 3, 1'b1, "rd1028");
        check("rd1028_data", o_data, 32'hDEADBEEF);
        check("rd1028_err", 32'(o_err), 32'd0);

        // bad address reads
        access(1'b1, 1'b0, 32'd1025, 32'd0, 4'hF, 3, 1'b0, "rd_misaligned");
        check("rd_misaligned_err", 32'(o_err), 32'd1);
        check("rd_misaligned_data", o_data, 32'd0);
        access(1'b1, 1'b0, 32'd1020, 32'd0, 4'hF, 3, 1'b0, "rd_below");
        check("rd_below_err", 32'(o_err), 32'd1);
        check("rd_below_data", o_data, 32'd0);
        access(1'b1, 1'b0, 32'd1280, 32'd0, 4'hF, 3, 1'b0, "rd_past_end");
        check("rd_past_end_err", 32'(o_err), 32'd1);
        check("rd_past_end_data", o_data, 32'd0);

        // bad address writes must not touch storage (1025/1280 alias onto word 0)
        access(1'b0, 1'b1, 32'd1025, 32'h11111111, 4'hF, 3, 1'b0, "wr_misaligned");
        check("wr_misaligned_err", 32'(o_err), 32'd1);
        access(1'b0, 1'b1, 32'd1020, 32'h22222222, 4'hF, 3, 1'b0, "wr_below");
        check("wr_below_err", 32'(o_err), 32'd1);
        access(1'b0, 1'b1, 32'd1280, 32'h33333333, 4'hF, 3, 1'b0, "wr_past_end");
        check("wr_past_end_err", 32'(o_err), 32'd1);
        access(1'b1, 1'b0, 32'd1024, 32'd0, 4'hF, 3, 1'b0, "rd1024_after_bad");
        check("rd1024_after_bad_data", o_data, 32'd0);
        check("rd1024_after_bad_err", 32'(o_err), 32'd0);

        // both enables high is an error and writes nothing
        access(1'b1, 1'b1, 32'd1028, 32'h44444444, 4'hF, 3, 1'b0, "both_en");
        check("both_en_err", 32'(o_err), 32'd1);
        check("both_en_data", o_data, 32'd0);
        access(1'b1, 1'b0, 32'd1028, 32'd0, 4'hF, 3, 1'b1, "rd1028_after_both");
        check("rd1028_after_both_data", o_data, 32'hDEADBEEF);

        // reset while a write is waiting
        @(negedge clk);
        r_en = 1'b0;
        w_en = 1'b1;
        addr = 32'd1032;
        din  = 32'h12345678;
        @(negedge clk);
        #1;
        check("rst_mid_in_wait", o_state, 32'(DMEM_WAIT));
        rst  = 1'b1;
        w_en = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_state", o_state, 32'(DMEM_IDLE));
        rst  = 1'b0;
        seen = o_ready;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            seen = seen | o_ready;
        end
        check("rst_mid_no_ready", 32'(seen), 32'd0);
        access(1'b1, 1'b0, 32'd1032, 32'd0, 4'hF, 3, 1'b0, "rd1032_after_rst");
        check("rd1032_after_rst_data", o_data, 32'd0);
        access(1'b1, 1'b0, 32'd1028, 32'd0, 4'hF, 3, 1'b1, "rd1028_after_rst");
        check("rd1028_after_rst_data", o_data, 32'd0);

        // LATENCY=1 instance
        sel = 1'b1;
        do_reset();
        access(1'b0, 1'b1, 32'd1036, 32'hA5A5A5A5, 4'hF, 1, 1'b0, "l1_wr1036");
        check("l1_wr1036_err", 32'(o_err), 32'd0);
        access(1'b1, 1'b0, 32'd1036, 32'd0, 4'hF, 1, 1'b1, "l1_rd1036");
        check("l1_rd1036_data", o_data, 32'hA5A5A5A5);
        access(1'b1, 1'b1, 32'd1036, 32'h0, 4'hF, 1, 1'b1, "l1_both_en");
        check("l1_both_en_err", 32'(o_err), 32'd1);
        check("l1_both_en_data", o_data, 32'd0);

`ifdef DMEM_BYTE_EN_EN
        // byte lanes: clear lanes 0 and 2, then an empty mask changes nothing
        access(1'b0, 1'b1, 32'd1040, 32'hFFFFFFFF, 4'hF, 1, 1'b0, "be_wr_all");
        access(1'b0, 1'b1, 32'd1040, 32'h00000000, 4'b0101, 1, 1'b0, "be_wr_0101");
        access(1'b1, 1'b0, 32'd1040, 32'd0, 4'h0, 1, 1'b0, "be_rd");
        check("be_rd_data", o_data, 32'hFF00FF00);
        access(1'b0, 1'b1, 32'd1040, 32'h12345678, 4'h0, 1, 1'b0, "be_wr_none");
        check("be_wr_none_err", 32'(o_err), 32'd0);
        access(1'b1, 1'b0, 32'd1040, 32'd0, 4'hF, 1, 1'b1, "be_rd2");
        check("be_rd2_data", o_data, 32'hFF00FF00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
